// File: rtl/dls_pkg.sv
// Shared definitions for the lockstep checker.
//   dls_state_t    : checker FSM states (CHECK, SUSPECT, ERROR)
//   DLS_DMR/DLS_TMR: legal redundancy levels
//   DLS_DMR_FAULTY : FAULTY_COPY value reported in DMR mode. With two copies
//                    there is no vote, so the faulty copy cannot be identified.
//   DLS_RUN_W      : width of the consecutive-mismatch run counter (THRESH <= 255)
package dls_pkg;
   typedef enum logic [1:0] {
      CHECK   = 2'd0,
      SUSPECT = 2'd1,
      ERROR   = 2'd2
   } dls_state_t;

   localparam int         DLS_DMR        = 2;
   localparam int         DLS_TMR        = 3;
   localparam logic [2:0] DLS_DMR_FAULTY = 3'b011;
   localparam int         DLS_RUN_W      = 8;
endpackage

// File: rtl/dls_voter.sv
// Purely combinational bitwise 2-of-3 majority voter.
//   a, b, c : WIDTH-bit inputs
//   y       : per-bit majority of a, b and c
module dls_voter #(
   parameter int WIDTH = 43
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] y
);
   assign y = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/dls_lockstep_checker.sv
// Lockstep checker for two (DMR) or three (TMR) redundant peripheral copies.
// On every enabled cycle the copies are compared under a don't-care mask.
// A run of THRESH consecutive enabled mismatches latches a sticky error, and
// the first erroring sample's syndrome is captured. A saturating count of
// mismatching samples is also kept.
//   HCLK, HRESETn       : clock, synchronous active-low reset
//   CMP_EN              : compare this cycle's copies
//   MASK                : 1 = bit excluded from comparison
//   COPY0..COPY2        : copy outputs (COPY2 is unused in DMR)
//   ERR_CLR             : clear sticky error, syndrome and counter
//   VOTED_OUT           : registered majority (TMR) or COPY0 (DMR)
//   MISMATCH            : registered, last cycle was an enabled mismatch
//   DLS_ERROR           : sticky lockstep error
//   ERR_COUNT           : saturating count of mismatching samples
//   FIRST_DIFF          : masked difference vector of the first erroring sample
//   FAULTY_COPY         : copies disagreeing with the vote at the first error
module dls_lockstep_checker import dls_pkg::*; #(
   parameter int NCOPIES = 2,
   parameter int WIDTH   = 43,
   parameter int THRESH  = 1,
   parameter int CNT_W   = 8
) (
   input  logic             HCLK,
   input  logic             HRESETn,
   input  logic             CMP_EN,
   input  logic [WIDTH-1:0] MASK,
   input  logic [WIDTH-1:0] COPY0,
   input  logic [WIDTH-1:0] COPY1,
   input  logic [WIDTH-1:0] COPY2,
   input  logic             ERR_CLR,
   output logic [WIDTH-1:0] VOTED_OUT,
   output logic             MISMATCH,
   output logic             DLS_ERROR,
   output logic [CNT_W-1:0] ERR_COUNT,
   output logic [WIDTH-1:0] FIRST_DIFF,
   output logic [2:0]       FAULTY_COPY
);
   localparam logic [DLS_RUN_W-1:0] THRESH_V = DLS_RUN_W'(THRESH);

   if (!(NCOPIES == DLS_DMR || NCOPIES == DLS_TMR) || THRESH < 1 || THRESH > 255) begin : g_bad_param
      $error("dls_lockstep_checker: NCOPIES must be 2 or 3, THRESH must be 1..255");
   end

   logic [WIDTH-1:0] vote;
   logic [WIDTH-1:0] diff;
   logic [2:0]       disagree;

   if (NCOPIES == DLS_TMR) begin : g_tmr
      dls_voter #(.WIDTH(WIDTH)) u_voter (
         .a (COPY0),
         .b (COPY1),
         .c (COPY2),
         .y (vote)
      );
      assign diff     = ((COPY0 ^ vote) | (COPY1 ^ vote) | (COPY2 ^ vote)) & ~MASK;
      assign disagree = {|((COPY2 ^ vote) & ~MASK),
                         |((COPY1 ^ vote) & ~MASK),
                         |((COPY0 ^ vote) & ~MASK)};
   end else begin : g_dmr
      // Third copy does not exist in DMR; tie it off explicitly.
      logic unused_copy2;
      assign unused_copy2 = ^COPY2;
      assign vote         = COPY0;
      assign diff         = (COPY0 ^ COPY1) & ~MASK;
      assign disagree     = DLS_DMR_FAULTY;
   end

   logic                 mism;
   logic [DLS_RUN_W-1:0] run;
   logic [DLS_RUN_W-1:0] run_nxt;
   dls_state_t           state;

   assign mism    = CMP_EN & (|diff);
   assign run_nxt = run + 1'b1;

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state       <= CHECK;
         run         <= '0;
         VOTED_OUT   <= '0;
         MISMATCH    <= 1'b0;
         DLS_ERROR   <= 1'b0;
         ERR_COUNT   <= '0;
         FIRST_DIFF  <= '0;
         FAULTY_COPY <= '0;
      end else begin
         VOTED_OUT <= vote;
         if (ERR_CLR) begin
            // Clear wins; a mismatch sampled in the same cycle is dropped.
            state       <= CHECK;
            run         <= '0;
            MISMATCH    <= 1'b0;
            DLS_ERROR   <= 1'b0;
            ERR_COUNT   <= '0;
            FIRST_DIFF  <= '0;
            FAULTY_COPY <= '0;
         end else begin
            MISMATCH <= mism;
            if (mism && ERR_COUNT != {CNT_W{1'b1}})
               ERR_COUNT <= ERR_COUNT + 1'b1;
            case (state)
               CHECK, SUSPECT: begin
                  if (mism) begin
                     run <= run_nxt;
                     if (run_nxt == THRESH_V) begin
                        state       <= ERROR;
                        DLS_ERROR   <= 1'b1;
                        FIRST_DIFF  <= diff;
                        FAULTY_COPY <= disagree;
                     end else begin
                        state <= SUSPECT;
                     end
                  end else if (CMP_EN) begin
                     run   <= '0;
                     state <= CHECK;
                  end
               end
               ERROR:   ; // absorbing; syndrome is frozen
               default: state <= CHECK;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_dls_lockstep_checker.sv
// Bench for dls_lockstep_checker. Four configurations share one stimulus:
//   0: DMR THRESH=1 CNT_W=8   1: DMR THRESH=3 CNT_W=8
//   2: TMR THRESH=1 CNT_W=8   3: DMR THRESH=1 CNT_W=2
// The driver computes expected outputs from a per-bit reference model and
// queues them; the monitor pops and compares after each clock edge.
module tb_dls_lockstep_checker;
   localparam int W = 43;
   localparam int N = 4;

   typedef struct packed {
      logic [W-1:0] voted;
      logic         mism;
      logic         err;
      logic [7:0]   cnt;
      logic [W-1:0] fd;
      logic [2:0]   fc;
   } obs_t;
   typedef obs_t [N-1:0] obs4_t;

   function automatic int cfg_nc(int i); return (i == 2) ? 3 : 2; endfunction
   function automatic int cfg_th(int i); return (i == 1) ? 3 : 1; endfunction
   function automatic int cfg_cw(int i); return (i == 3) ? 2 : 8; endfunction

   logic         HCLK = 1'b1;
   logic         HRESETn = 1'b0;
   logic         CMP_EN = 1'b0;
   logic         ERR_CLR = 1'b0;
   logic [W-1:0] MASK = '0, COPY0 = '0, COPY1 = '0, COPY2 = '0;
   obs_t         act [N];

   always #5 HCLK = ~HCLK;

   for (genvar g = 0; g < N; g++) begin : g_dut
      localparam int CW = cfg_cw(g);
      logic [W-1:0]  vo, fd;
      logic          mm, de;
      logic [CW-1:0] cnt;
      logic [2:0]    fc;
      dls_lockstep_checker #(.NCOPIES(cfg_nc(g)), .WIDTH(W), .THRESH(cfg_th(g)), .CNT_W(CW)) u_dut (
         .HCLK        (HCLK),
         .HRESETn     (HRESETn),
         .CMP_EN      (CMP_EN),
         .MASK        (MASK),
         .COPY0       (COPY0),
         .COPY1       (COPY1),
         .COPY2       (COPY2),
         .ERR_CLR     (ERR_CLR),
         .VOTED_OUT   (vo),
         .MISMATCH    (mm),
         .DLS_ERROR   (de),
         .ERR_COUNT   (cnt),
         .FIRST_DIFF  (fd),
         .FAULTY_COPY (fc)
      );
      assign act[g] = {vo, mm, de, 8'(cnt), fd, fc};
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         if (errors <= 40) $display("FAIL %s: got %h expected %h", nm, a, e);
      end
   endtask

   // Reference model state per configuration
   int           run_m [N];
   bit           err_m [N];
   int           cnt_m [N];
   logic [W-1:0] fd_m  [N];
   logic [2:0]   fc_m  [N];

   task automatic model_step(int i, bit rst, bit en, bit clr, logic [W-1:0] m,
                             logic [W-1:0] c0, logic [W-1:0] c1, logic [W-1:0] c2,
                             output obs_t o);
      int           n = cfg_nc(i);
      int           cmax = (1 << cfg_cw(i)) - 1;
      logic [W-1:0] v, d;
      logic [2:0]   dis;
      bit           mism;
      dis = (n == 3) ? 3'b000 : 3'b011;
      for (int b = 0; b < W; b++) begin
         int ones = int'(c0[b]) + int'(c1[b]) + ((n == 3) ? int'(c2[b]) : 0);
         v[b] = (n == 3) ? (ones >= 2) : c0[b];
         d[b] = !m[b] && (c0[b] != v[b] || c1[b] != v[b] || (n == 3 && c2[b] != v[b]));
         if (n == 3 && !m[b]) begin
            if (c0[b] != v[b]) dis[0] = 1'b1;
            if (c1[b] != v[b]) dis[1] = 1'b1;
            if (c2[b] != v[b]) dis[2] = 1'b1;
         end
      end
      mism = en && (d != '0);
      o = '0;
      if (rst || clr) begin
         run_m[i] = 0; err_m[i] = 0; cnt_m[i] = 0; fd_m[i] = '0; fc_m[i] = '0;
      end else begin
         o.mism = mism;
         if (mism) begin
            if (cnt_m[i] < cmax) cnt_m[i]++;
            if (!err_m[i]) begin
               run_m[i]++;
               if (run_m[i] >= cfg_th(i)) begin
                  err_m[i] = 1; fd_m[i] = d; fc_m[i] = dis;
               end
            end
         end else if (en) begin
            run_m[i] = 0;
         end
      end
      if (!rst) o.voted = v;
      o.err = err_m[i];
      o.cnt = 8'(cnt_m[i]);
      o.fd  = fd_m[i];
      o.fc  = fc_m[i];
   endtask

   obs4_t exp_q[$];

   task automatic cyc(bit rst, bit en, bit clr, logic [W-1:0] m,
                      logic [W-1:0] c0, logic [W-1:0] c1, logic [W-1:0] c2);
      obs4_t e;
      @(negedge HCLK);
      HRESETn = !rst; CMP_EN = en; ERR_CLR = clr;
      MASK = m; COPY0 = c0; COPY1 = c1; COPY2 = c2;
      for (int i = 0; i < N; i++) model_step(i, rst, en, clr, m, c0, c1, c2, e[i]);
      exp_q.push_back(e);
   endtask

   task automatic settle;
      @(posedge HCLK); #2;
   endtask

   function automatic logic [W-1:0] rnd43();
      return W'({$urandom, $urandom});
   endfunction

   // Monitor: compares every DUT output against the queued expectation
   initial begin
      obs4_t e;
      forever begin
         @(posedge HCLK); #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int i = 0; i < N; i++) begin
               chk($sformatf("cfg%0d VOTED_OUT", i), 64'(act[i].voted), 64'(e[i].voted));
               chk($sformatf("cfg%0d MISMATCH", i), 64'(act[i].mism), 64'(e[i].mism));
               chk($sformatf("cfg%0d DLS_ERROR", i), 64'(act[i].err), 64'(e[i].err));
               chk($sformatf("cfg%0d ERR_COUNT", i), 64'(act[i].cnt), 64'(e[i].cnt));
               chk($sformatf("cfg%0d FIRST_DIFF", i), 64'(act[i].fd), 64'(e[i].fd));
               chk($sformatf("cfg%0d FAULTY_COPY", i), 64'(act[i].fc), 64'(e[i].fc));
            end
         end
      end
   end

   // Driver: directed scenarios with spot checks, then random traffic
   initial begin
      logic [W-1:0] base, all1, c0, c1, c2, m, f;
      base = 43'h1234;
      all1 = '1;

      // reset
      cyc(1, 0, 0, '0, base, base, base);
      cyc(1, 0, 0, '0, base, base, base);
      settle();
      chk("reset DLS_ERROR", 64'(act[0].err), 0);
      chk("reset VOTED_OUT", 64'(act[0].voted), 0);
      chk("reset ERR_COUNT", 64'(act[0].cnt), 0);

      // DMR THRESH=1: single bit-5 flip
      cyc(0, 1, 0, '0, base, base ^ 43'h20, base);
      settle();
      chk("dmr1 MISMATCH", 64'(act[0].mism), 1);
      chk("dmr1 DLS_ERROR", 64'(act[0].err), 1);
      chk("dmr1 ERR_COUNT", 64'(act[0].cnt), 1);
      chk("dmr1 FIRST_DIFF", 64'(act[0].fd), 64'h20);
      chk("dmr1 FAULTY_COPY", 64'(act[0].fc), 3'b011);

      // DMR THRESH=3: mismatch, mismatch, match -> no error
      cyc(0, 0, 1, '0, base, base, base);
      cyc(0, 1, 0, '0, base, base ^ 43'h1, base);
      cyc(0, 1, 0, '0, base, base ^ 43'h2, base);
      cyc(0, 1, 0, '0, base, base, base);
      settle();
      chk("dmr3 no error", 64'(act[1].err), 0);
      chk("dmr3 ERR_COUNT", 64'(act[1].cnt), 2);
      // three enabled mismatches separated by disabled cycles
      cyc(0, 1, 0, '0, base, base ^ 43'h4, base);
      cyc(0, 0, 0, '0, base, base, base);
      cyc(0, 1, 0, '0, base, base ^ 43'h4, base);
      cyc(0, 0, 0, '0, base, base ^ 43'h8, base);
      settle();
      chk("dmr3 gap MISMATCH", 64'(act[1].mism), 0);
      chk("dmr3 two of three", 64'(act[1].err), 0);
      cyc(0, 1, 0, '0, base, base ^ 43'h4, base);
      settle();
      chk("dmr3 third", 64'(act[1].err), 1);
      chk("dmr3 FIRST_DIFF", 64'(act[1].fd), 64'h4);

      // TMR: copy2 fully inverted, vote stays correct
      cyc(0, 0, 1, '0, base, base, base);
      cyc(0, 1, 0, '0, base, base, ~base);
      settle();
      chk("tmr VOTED_OUT", 64'(act[2].voted), 64'h1234);
      chk("tmr DLS_ERROR", 64'(act[2].err), 1);
      chk("tmr FAULTY_COPY", 64'(act[2].fc), 3'b100);

      // full mask: nothing may ever mismatch
      cyc(0, 0, 1, '0, base, base, base);
      for (int k = 0; k < 10; k++) begin
         cyc(0, 1, 0, all1, rnd43(), rnd43(), rnd43());
         settle();
         chk("mask MISMATCH", 64'(act[0].mism), 0);
      end
      chk("mask DLS_ERROR", 64'(act[0].err), 0);
      chk("mask ERR_COUNT", 64'(act[0].cnt), 0);

      // CNT_W=2 saturation, then clear with a simultaneous mismatch
      for (int k = 0; k < 5; k++) cyc(0, 1, 0, '0, base, base ^ 43'h10, base);
      settle();
      chk("sat ERR_COUNT", 64'(act[3].cnt), 3);
      cyc(0, 1, 1, '0, base, base ^ 43'h10, base);
      settle();
      chk("clr ERR_COUNT", 64'(act[3].cnt), 0);
      chk("clr DLS_ERROR", 64'(act[3].err), 0);
      chk("clr FIRST_DIFF", 64'(act[3].fd), 0);

      // reset while in ERROR, then re-capture
      cyc(0, 1, 0, '0, base, base ^ 43'h40, base);
      cyc(1, 1, 0, '0, base, base ^ 43'h40, base);
      settle();
      chk("rst DLS_ERROR", 64'(act[0].err), 0);
      chk("rst FIRST_DIFF", 64'(act[0].fd), 0);
      chk("rst VOTED_OUT", 64'(act[0].voted), 0);
      cyc(0, 1, 0, '0, '0, 43'h1, '0);
      settle();
      chk("recapture FIRST_DIFF", 64'(act[0].fd), 1);

      // random traffic
      for (int k = 0; k < 2000; k++) begin
         c0 = rnd43();
         f  = 43'h1 << $urandom_range(0, W - 1);
         c1 = ($urandom_range(0, 3) == 0) ? (c0 ^ f) : c0;
         f  = 43'h1 << $urandom_range(0, W - 1);
         c2 = ($urandom_range(0, 3) == 0) ? (c0 ^ f) : c0;
         m  = ($urandom_range(0, 1) == 0) ? '0 : (rnd43() & rnd43() & rnd43());
         cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 49) == 0, m, c0, c1, c2);
      end

      @(posedge HCLK); #3;
      chk("queue drained", 64'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/dls_lockstep_checker.md
# dls_lockstep_checker

Parametrised lockstep checker for redundant AHB peripheral instances, the next generation of the fixed-width DMR comparator. It compares a W-bit output bundle from two (DMR) or three (TMR) identical peripheral copies every enabled cycle, applies a per-bit don't-care mask and a consecutive-mismatch threshold, and latches a sticky error. It also captures a first-fault syndrome and keeps a saturating mismatch count. In TMR mode it also drives a bitwise-majority output so that a single faulty copy is masked.

## Interface
- NCOPIES, 2, redundancy level; only 2 (DMR) and 3 (TMR) are legal
- WIDTH, 43, compared bundle width (HRDATA 32 + HREADYOUT + HSYNC + VSYNC + RGB 8)
- THRESH, 1, consecutive mismatching samples before error; range 1..255
- CNT_W, 8, ERR_COUNT width
- Reset: one clock; reset is synchronous and active-low.
- HCLK  in  1  clock
- HRESETn  in  1  synchronous active-low reset
- CMP_EN  in  1  sample this cycle's copies
- MASK  in  WIDTH  1 = bit excluded from comparison
- COPY0, COPY1, COPY2  in  WIDTH  copy outputs; COPY2 ignored when NCOPIES=2
- ERR_CLR  in  1  clear sticky state, syndrome and counter
- VOTED_OUT  out  WIDTH  registered majority (TMR) or COPY0 (DMR)
- MISMATCH  out  1  registered: last sampled cycle mismatched
- DLS_ERROR  out  1  sticky lockstep error
- ERR_COUNT  out  CNT_W  saturating count of mismatching samples
- FIRST_DIFF  out  WIDTH  masked difference vector of the first erroring sample
- FAULTY_COPY  out  3  bitmap of copies disagreeing with the vote at the first error; DMR reports 3'b011

## Operation
- Difference vector D:
  - DMR: (COPY0^COPY1)&~MASK
  - TMR: V = maj(COPY0,COPY1,COPY2) bitwise; D = ((COPY0^V)|(COPY1^V)|(COPY2^V))&~MASK
- Sample mismatch: CMP_EN & |D.
- FSM states: CHECK, SUSPECT, ERROR.
  - CHECK: a mismatching sample increments run counter to 1. If THRESH=1, go to ERROR. Otherwise go to SUSPECT.
  - SUSPECT: a mismatching sample increments the run counter. When it reaches THRESH, go to ERROR. A matching sample with CMP_EN=1 clears the run counter and returns to CHECK.
  - Any state: CMP_EN=0 holds the run counter and state unchanged.
  - ERROR: absorbing until ERR_CLR or reset. Further mismatches still increment ERR_COUNT.
- On the CHECK/SUSPECT→ERROR transition, capture D into FIRST_DIFF and the per-copy disagreement bitmap into FAULTY_COPY. Never overwrite them while in ERROR.
- ERR_COUNT increments on every mismatching sample and saturates at 2^CNT_W−1.
- ERR_CLR takes priority:
  - State goes to CHECK; run counter, ERR_COUNT, FIRST_DIFF and FAULTY_COPY go to 0.
  - A mismatch presented in the same cycle is discarded.
- MASK bits never cause mismatch but still pass through VOTED_OUT.
- TMR single-copy fault: VOTED_OUT stays correct; DLS_ERROR still asserts (detection is not suppressed).

## Timing
- Reset values: VOTED_OUT=0, MISMATCH=0, DLS_ERROR=0, ERR_COUNT=0, FIRST_DIFF=0, FAULTY_COPY=0; state CHECK, run counter 0.
- All outputs are registered; no combinational input→output path.
- VOTED_OUT and MISMATCH have 1-cycle latency and update every cycle. MISMATCH is forced 0 when CMP_EN=0.
- DLS_ERROR asserts after the edge that samples the THRESH-th consecutive enabled mismatch. With THRESH=1 that is 1 cycle after the faulty input.
- Reset asserted mid-SUSPECT or in ERROR returns everything to reset values at the next edge.

## Structure
- Shared package dls_pkg holds:
  - state enum dls_state_t {CHECK, SUSPECT, ERROR}
  - DLS_DMR=2 and DLS_TMR=3 constants
  - DMR FAULTY_COPY constant 3'b011
- Sub-module dls_voter is a purely combinational WIDTH-parametrised bitwise majority voter. It is instantiated only when NCOPIES=3 (generate).
- Elaboration check: NCOPIES not in {2,3} or THRESH=0 is an error.

## Test plan
- DMR, THRESH=1: COPY1 bit 5 flipped for one cycle with CMP_EN=1 → next cycle MISMATCH=1, DLS_ERROR=1, ERR_COUNT=1, FIRST_DIFF=43'h20, FAULTY_COPY=3'b011.
- DMR, THRESH=3:
  - Mismatch, mismatch, match → DLS_ERROR stays 0, ERR_COUNT=2.
  - Then 3 consecutive mismatches separated by CMP_EN=0 gaps → DLS_ERROR=1 after the third enabled sample.
- TMR: COPY2=~COPY0 with COPY0=COPY1=43'h1234 → VOTED_OUT=43'h1234, DLS_ERROR=1, FAULTY_COPY=3'b100.
- MASK=all ones with all copies differing → MISMATCH, DLS_ERROR and ERR_COUNT stay 0 indefinitely.
- CNT_W=2: 5 mismatches → ERR_COUNT=3 (saturated). ERR_CLR together with a mismatch → all cleared, ERR_COUNT=0.
- HRESETn low for one cycle while in ERROR → all outputs at reset values on the next edge; a fresh mismatch afterwards re-captures FIRST_DIFF.
